// File: rtl/mult_result_accumulator_if.sv
// Product-in / dot-product-out bus for mult_result_accumulator.
//   master: drives z, z_valid, clear, acc_ready; observes acc_out, acc_valid, count, overflow
//   slave : the accumulator's view (inverse directions)
interface mult_result_accumulator_if #(
    parameter int unsigned PROD_W = 7,
    parameter int unsigned ACC_W  = 9,
    parameter int unsigned CNT_W  = 2
);
    logic [PROD_W-1:0] z;
    logic              z_valid;
    logic              clear;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output z, z_valid, clear, acc_ready,
        input  acc_out, acc_valid, count, overflow
    );

    modport slave (
        input  z, z_valid, clear, acc_ready,
        output acc_out, acc_valid, count, overflow
    );
endinterface

// File: rtl/mult_result_accumulator.sv
// Sums VEC_LEN consecutive single-cycle multiplier products into one result
// and presents it on a registered valid/ready output. Accumulation never
// stalls (the multiplier cannot be backpressured); a result that completes
// while the output register is still occupied is dropped and flagged in a
// sticky overflow bit.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus.z      : product, sampled when bus.z_valid=1
//   bus.z_valid: one-cycle product pulse
//   bus.clear  : synchronous restart of the partial vector, clears overflow
//   bus.acc_out/acc_valid/acc_ready : result handshake
//   bus.count  : products held in the current partial vector
//   bus.overflow : sticky dropped-result flag
module mult_result_accumulator #(
    parameter int unsigned PROD_W  = 7,
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned ACC_W   = 9,
    parameter int unsigned CNT_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    mult_result_accumulator_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e        out_state_q, out_state_d;
    logic [ACC_W-1:0]  psum_q,      psum_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [ACC_W-1:0]  acc_out_q,   acc_out_d;
    logic              overflow_q,  overflow_d;

    logic [PROD_W-1:0] z_in;
    logic [ACC_W-1:0]  z_ext_c;
    logic [ACC_W-1:0]  sum_c;
    logic              xfer_c;

    // Zero-extend the product; the sum wraps modulo 2^ACC_W.
    assign z_in    = bus.z;
    assign z_ext_c = ACC_W'(z_in);
    assign sum_c   = psum_q + z_ext_c;
    assign xfer_c  = (out_state_q == OUT_FULL) && bus.acc_ready;

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state_q <= OUT_EMPTY;
            psum_q      <= '0;
            count_q     <= '0;
            acc_out_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            psum_q      <= psum_d;
            count_q     <= count_d;
            acc_out_q   <= acc_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state: output handshake first, then accumulation, which may
    // reload the output register on the same edge a transfer empties it.
    always_comb begin
        out_state_d = out_state_q;
        psum_d      = psum_q;
        count_d     = count_q;
        acc_out_d   = acc_out_q;
        overflow_d  = overflow_q;

        if (xfer_c) begin
            out_state_d = OUT_EMPTY;
        end

        if (bus.clear) begin
            // clear wins over a coincident product; the pending result stays.
            psum_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.z_valid) begin
            if (count_q == LAST_CNT) begin
                psum_d  = '0;
                count_d = '0;
                if ((out_state_q == OUT_EMPTY) || xfer_c) begin
                    acc_out_d   = sum_c;
                    out_state_d = OUT_FULL;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                psum_d  = sum_c;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = (out_state_q == OUT_FULL);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Randomized and directed bench for mult_result_accumulator, with a
// behavioural model of the vector sum and output slot. A second instance
// with an 8-bit accumulator shares the same stimulus to show wrap-around.
module tb_mult_result_accumulator;

    localparam int unsigned PROD_W  = 7;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned ACC_W   = 9;
    localparam int unsigned ACC_W8  = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int          MOD9    = 1 << ACC_W;
    localparam int          MOD8    = 1 << ACC_W8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_result_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W),  .CNT_W(CNT_W)) bus ();
    mult_result_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W8), .CNT_W(CNT_W)) bus8 ();

    assign bus8.z         = bus.z;
    assign bus8.z_valid   = bus.z_valid;
    assign bus8.clear     = bus.clear;
    assign bus8.acc_ready = bus.acc_ready;

    mult_result_accumulator #(
        .PROD_W(PROD_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    mult_result_accumulator #(
        .PROD_W(PROD_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W8), .CNT_W(CNT_W)
    ) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: running sum of the current vector, number of products taken,
    // one output slot (valid + full-precision value), sticky drop flag.
    int   m_sum   = 0;
    int   m_n     = 0;
    int   m_res   = 0;
    logic m_valid = 1'b0;
    logic m_ovf   = 1'b0;

    initial begin
        bit xfer;
        bit was_valid;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_sum = 0; m_n = 0; m_res = 0; m_valid = 1'b0; m_ovf = 1'b0;
            end else begin
                was_valid = m_valid;
                xfer      = m_valid && bus.acc_ready;
                if (xfer) m_valid = 1'b0;
                if (bus.clear) begin
                    m_sum = 0; m_n = 0; m_ovf = 1'b0;
                end else if (bus.z_valid) begin
                    m_sum = m_sum + int'(bus.z);
                    m_n   = m_n + 1;
                    if (m_n == int'(VEC_LEN)) begin
                        if (!was_valid || xfer) begin
                            m_res   = m_sum;
                            m_valid = 1'b1;
                        end else begin
                            m_ovf = 1'b1;
                        end
                        m_sum = 0;
                        m_n   = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("acc_valid",  32'(bus.acc_valid),  32'(m_valid));
            check("acc_out",    32'(bus.acc_out),    32'(m_res % MOD9));
            check("count",      32'(bus.count),      32'(m_n));
            check("overflow",   32'(bus.overflow),   32'(m_ovf));
            check("acc_valid8", 32'(bus8.acc_valid), 32'(m_valid));
            check("acc_out8",   32'(bus8.acc_out),   32'(m_res % MOD8));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int v);
        bus.z       = PROD_W'(v);
        bus.z_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.z_valid = 1'b0;
    endtask

    initial begin
        bus.z         = '0;
        bus.z_valid   = 1'b0;
        bus.clear     = 1'b0;
        bus.acc_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_acc_valid", 32'(bus.acc_valid), 32'd0);
        check("rst_acc_out",   32'(bus.acc_out),   32'd0);
        check("rst_count",     32'(bus.count),     32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Spaced vector 3,5,7,2 -> 17, one-cycle valid.
        bus.acc_ready = 1'b1;
        pulse(3); check("t1_count1", 32'(bus.count), 32'd1); idle(7);
        pulse(5); check("t1_count2", 32'(bus.count), 32'd2); idle(7);
        pulse(7); check("t1_count3", 32'(bus.count), 32'd3); idle(7);
        pulse(2);
        check("t1_count0", 32'(bus.count),     32'd0);
        check("t1_valid",  32'(bus.acc_valid), 32'd1);
        check("t1_out",    32'(bus.acc_out),   32'd17);
        check("t1_ovf",    32'(bus.overflow),  32'd0);
        idle(1);
        check("t1_valid_drop", 32'(bus.acc_valid), 32'd0);

        // Max products: 508 in 9 bits, 252 in 8 bits.
        for (int i = 0; i < 4; i++) pulse(127);
        check("t2_out9", 32'(bus.acc_out),  32'd508);
        check("t2_out8", 32'(bus8.acc_out), 32'd252);
        idle(1);

        // Backpressure drop and clear of the sticky flag.
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(1);
        check("t3_valid", 32'(bus.acc_valid), 32'd1);
        check("t3_out",   32'(bus.acc_out),   32'd4);
        for (int i = 0; i < 4; i++) pulse(2);
        check("t3_ovf",      32'(bus.overflow), 32'd1);
        check("t3_out_held", 32'(bus.acc_out),  32'd4);
        idle(2);
        check("t3_out_held2", 32'(bus.acc_out), 32'd4);
        bus.acc_ready = 1'b1;
        idle(1);
        check("t3_valid_drop", 32'(bus.acc_valid), 32'd0);
        check("t3_ovf_sticky", 32'(bus.overflow),  32'd1);
        bus.clear = 1'b1;
        idle(1);
        bus.clear = 1'b0;
        check("t3_ovf_clear", 32'(bus.overflow), 32'd0);

        // Same-edge transfer and reload.
        bus.acc_ready = 1'b0;
        pulse(1); pulse(2); pulse(3); pulse(4);
        check("t4_first", 32'(bus.acc_out), 32'd10);
        pulse(5); pulse(5); pulse(5);
        bus.acc_ready = 1'b1;
        pulse(5);
        check("t4_valid", 32'(bus.acc_valid), 32'd1);
        check("t4_out",   32'(bus.acc_out),   32'd20);
        check("t4_ovf",   32'(bus.overflow),  32'd0);
        idle(1);
        check("t4_valid_drop", 32'(bus.acc_valid), 32'd0);

        // clear mid-vector beats a coincident product.
        pulse(4); pulse(4);
        check("t5_count2", 32'(bus.count), 32'd2);
        bus.clear   = 1'b1;
        bus.z       = PROD_W'(9);
        bus.z_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.clear   = 1'b0;
        bus.z_valid = 1'b0;
        check("t5_count0", 32'(bus.count), 32'd0);
        for (int i = 0; i < 4; i++) pulse(1);
        check("t5_out", 32'(bus.acc_out), 32'd4);
        idle(1);

        // Asynchronous reset mid-vector with a pending result and overflow.
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(1);
        for (int i = 0; i < 4; i++) pulse(2);
        pulse(6); pulse(6);
        check("t6_pre_count", 32'(bus.count),    32'd2);
        check("t6_pre_ovf",   32'(bus.overflow), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_valid", 32'(bus.acc_valid), 32'd0);
        check("t6_count", 32'(bus.count),     32'd0);
        check("t6_out",   32'(bus.acc_out),   32'd0);
        check("t6_ovf",   32'(bus.overflow),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.acc_ready = 1'b1;
        pulse(3); pulse(5); pulse(7); pulse(2);
        check("t6_out17", 32'(bus.acc_out), 32'd17);
        idle(1);

        // Randomized traffic, including rare asynchronous resets.
        repeat (3000) begin
            bus.z         = PROD_W'($urandom_range(0, 127));
            bus.z_valid   = ($urandom_range(0, 2) != 0);
            bus.clear     = ($urandom_range(0, 31) == 0);
            bus.acc_ready = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
        end
        bus.z_valid = 1'b0;
        bus.clear   = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
